qdr_ui_responder: RTL and testbench
===================================

Name: qdr_ui_responder

Overview:
- Synthesizable responder for the QDR II+ controller user interface (UI); it answers the write/read commands a traffic generator or user logic issues.
- Emulates the calibration handshake and backs the UI with on-chip block RAM, so initiators can run on boards or benches with no QDR device or controller present.
- Drop-in for the controller UI side: same command/data signalling, same init_calib_complete behaviour, fixed and parameterizable read latency.

Parameters:
DATA_WIDTH, 144, UI data width: 4-beat burst × 36 bits.
BW_WIDTH, 16, active-low byte-write enables; one per 9-bit byte.
ADDR_WIDTH, 19, UI address width, matching the device SA bus.
MEM_ADDR_BITS, 10, implemented depth = 2**MEM_ADDR_BITS words; upper address bits alias.
CALIB_CYCLES, 1000, cycles from reset release to init_calib_complete; minimum 1.
RD_LATENCY, 4, cycles from accepted read command to app_rd_valid; range 2..16.

Ports:
clk  input  1  UI clock; all logic is on the rising edge.
rst_clk  input  1  synchronous, active-high reset.
init_calib_complete  output  1  high once emulated calibration is done.
app_wr_cmd  input  1  write command strobe.
app_wr_addr  input  ADDR_WIDTH  write address.
app_wr_data  input  DATA_WIDTH  write data.
app_wr_bw_n  input  BW_WIDTH  byte-write enables, active-low.
app_rd_cmd  input  1  read command strobe.
app_rd_addr  input  ADDR_WIDTH  read address.
app_rd_valid  output  1  read data valid, one-cycle pulse per read.
app_rd_data  output  DATA_WIDTH  read data.
cmd_err  output  1  sticky flag: a command arrived while not calibrated.
addr_alias  output  1  sticky flag: an accepted address had nonzero bits above MEM_ADDR_BITS.
wr_count  output  32  accepted writes; saturates at all-ones.
rd_count  output  32  accepted reads; saturates at all-ones.

Behaviour:
- Reset (rst_clk=1 at a clk edge):
  - FSM goes to CALIB; the calibration counter clears.
  - init_calib_complete, app_rd_valid, cmd_err and addr_alias clear to 0.
  - app_rd_data clears to 0; wr_count and rd_count clear to 0.
  - All in-flight reads in the latency pipeline are discarded.
  - RAM contents are NOT cleared.
- FSM CALIB:
  - Counter increments each cycle.
  - When the count reaches CALIB_CYCLES-1, the FSM moves to READY.
  - init_calib_complete is registered high on the first READY cycle: CALIB_CYCLES cycles after the first cycle with rst_clk low.
- FSM READY:
  - Stays in READY until reset; there are no other exits.
  - init_calib_complete is held at 1.
- Command acceptance:
  - No backpressure: every strobe seen in READY is accepted in that cycle.
  - A write and a read may both be accepted in the same cycle.
  - A strobe seen in CALIB is ignored: no RAM access, no pipeline entry, no count change. cmd_err sets and holds until reset.
- Write:
  - Byte i (data bits [9i+8:9i]) is written to RAM[addr[MEM_ADDR_BITS-1:0]] only if app_wr_bw_n[i]=0.
  - Bytes with app_wr_bw_n[i]=1 keep their old value.
  - An all-ones app_wr_bw_n is still counted as an accepted write.
- Read:
  - A read accepted in cycle N gives app_rd_valid=1 in cycle N+RD_LATENCY, with data from RAM at that address.
  - Reads are returned in issue order, one output per accepted read.
  - Back-to-back reads give back-to-back valid pulses.
  - app_rd_data holds its last value while app_rd_valid=0.
- Same-cycle collision (read and write to the same aliased address): the read returns the OLD data (read-before-write). A read issued one or more cycles after the write returns the NEW data.
- Aliasing: the address is truncated to MEM_ADDR_BITS. If any upper bit of an accepted address is 1, addr_alias sets and holds until reset.
- Counters: increment by 1 per accepted command and stick at 32'hFFFFFFFF.
- Reset mid-operation: app_rd_valid is 0 from the cycle after reset is sampled. No stale read pulse is produced after reset is released.

Test Plan:
- Calibration: deassert rst_clk at cycle 0 with CALIB_CYCLES=1000 -> init_calib_complete=0 through cycle 999 and =1 from cycle 1000. A write strobe at cycle 10 -> cmd_err=1, wr_count=0.
- Single read/write: write addr 0x00005 with data 144'h1234…, bw_n=16'h0000, then read addr 0x00005 -> app_rd_valid pulse exactly 4 cycles after the read with matching data; wr_count=1, rd_count=1.
- Byte mask: write all-ones data, then write all-zeros data with bw_n=16'hFFFE, then read -> bits [8:0]=0 and all other bits =1.
- Collision and streaming: same-cycle write and read to addr 7 (old data 0xA, new 0xB) -> 0xA returned. Then 8 back-to-back reads of addrs 0..7 -> 8 consecutive valid cycles, in order.
- Alias: write addr 0x00400 (MEM_ADDR_BITS=10), read addr 0x00000 -> same data returned; addr_alias=1.
- Reset mid-flight: issue 3 reads, then assert rst_clk 2 cycles later -> no app_rd_valid pulses after that; init_calib_complete drops to 0 and calibration restarts.

Source files
------------

// File: rtl/qdr_ui_responder.sv
// QDR II+ controller user-interface responder: emulated calibration, block-RAM
// backing store with byte writes, and a fixed-latency in-order read pipeline.
module qdr_ui_responder #(
  parameter int DATA_WIDTH    = 144,
  parameter int BW_WIDTH      = 16,
  parameter int ADDR_WIDTH    = 19,
  parameter int MEM_ADDR_BITS = 10,
  parameter int CALIB_CYCLES  = 1000,
  parameter int RD_LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_clk,
  output logic                  init_calib_complete,
  input  logic                  app_wr_cmd,
  input  logic [ADDR_WIDTH-1:0] app_wr_addr,
  input  logic [DATA_WIDTH-1:0] app_wr_data,
  input  logic [BW_WIDTH-1:0]   app_wr_bw_n,
  input  logic                  app_rd_cmd,
  input  logic [ADDR_WIDTH-1:0] app_rd_addr,
  output logic                  app_rd_valid,
  output logic [DATA_WIDTH-1:0] app_rd_data,
  output logic                  cmd_err,
  output logic                  addr_alias,
  output logic [31:0]           wr_count,
  output logic [31:0]           rd_count
);

  localparam int BYTE_W = DATA_WIDTH / BW_WIDTH;
  localparam int DEPTH  = 2 ** MEM_ADDR_BITS;
  localparam int CNT_W  = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
  // The RAM read register is pipeline stage 0; app_rd_data is the final stage.
  localparam int PIPE_N = RD_LATENCY - 1;

  localparam logic [0:0] ST_CALIB = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]               state;
  logic [CNT_W-1:0]         calib_cnt;
  logic                     wr_accept;
  logic                     rd_accept;
  logic                     wr_aliased;
  logic                     rd_aliased;
  logic [MEM_ADDR_BITS-1:0] wr_idx;
  logic [MEM_ADDR_BITS-1:0] rd_idx;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [PIPE_N-1:0]        pipe_vld;
  logic [DATA_WIDTH-1:0]    pipe_dat [PIPE_N];

  assign wr_accept  = app_wr_cmd && (state == ST_READY);
  assign rd_accept  = app_rd_cmd && (state == ST_READY);
  assign wr_idx     = app_wr_addr[MEM_ADDR_BITS-1:0];
  assign rd_idx     = app_rd_addr[MEM_ADDR_BITS-1:0];
  assign wr_aliased = (app_wr_addr >> MEM_ADDR_BITS) != '0;
  assign rd_aliased = (app_rd_addr >> MEM_ADDR_BITS) != '0;

  always_ff @(posedge clk) begin
    if (rst_clk) begin
      state               <= ST_CALIB;
      calib_cnt           <= '0;
      init_calib_complete <= 1'b0;
    end else if (state == ST_CALIB) begin
      calib_cnt <= calib_cnt + CNT_W'(1);
      if (calib_cnt == CNT_W'(CALIB_CYCLES - 1)) begin
        state               <= ST_READY;
        init_calib_complete <= 1'b1;
      end
    end
  end

  // NOTE: the RAM and the read-data pipeline carry no reset so the array maps
  // onto block RAM; only the valid bits and visible outputs are reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int i = 0; i < BW_WIDTH; i++) begin
        if (!app_wr_bw_n[i]) begin
          mem[wr_idx][i*BYTE_W +: BYTE_W] <= app_wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
    // NOTE: non-blocking assignment makes a same-cycle read see the pre-write
    // contents, which is exactly the read-before-write collision behaviour.
    if (rd_accept) begin
      pipe_dat[0] <= mem[rd_idx];
    end
    for (int s = 1; s < PIPE_N; s++) begin
      pipe_dat[s] <= pipe_dat[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_clk) begin
      pipe_vld     <= '0;
      app_rd_valid <= 1'b0;
      app_rd_data  <= '0;
    end else begin
      pipe_vld[0] <= rd_accept;
      for (int s = 1; s < PIPE_N; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
      end
      app_rd_valid <= pipe_vld[PIPE_N-1];
      if (pipe_vld[PIPE_N-1]) begin
        app_rd_data <= pipe_dat[PIPE_N-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_clk) begin
      cmd_err    <= 1'b0;
      addr_alias <= 1'b0;
      wr_count   <= '0;
      rd_count   <= '0;
    end else begin
      if ((app_wr_cmd || app_rd_cmd) && (state == ST_CALIB)) begin
        cmd_err <= 1'b1;
      end
      if ((wr_accept && wr_aliased) || (rd_accept && rd_aliased)) begin
        addr_alias <= 1'b1;
      end
      if (wr_accept && (wr_count != '1)) begin
        wr_count <= wr_count + 32'd1;
      end
      if (rd_accept && (rd_count != '1)) begin
        rd_count <= rd_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_qdr_ui_responder.sv
// Self-checking bench for qdr_ui_responder: directed scenarios plus random
// traffic, all scored against a transaction-level memory/latency model.
module tb_qdr_ui_responder;

  localparam int DW  = 144;
  localparam int BWW = 16;
  localparam int AW  = 19;
  localparam int MAB = 10;
  localparam int CAL = 1000;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_clk = 1'b1;
  logic          init_calib_complete;
  logic          app_wr_cmd = 1'b0;
  logic [AW-1:0] app_wr_addr = '0;
  logic [DW-1:0] app_wr_data = '0;
  logic [BWW-1:0] app_wr_bw_n = '1;
  logic          app_rd_cmd = 1'b0;
  logic [AW-1:0] app_rd_addr = '0;
  logic          app_rd_valid;
  logic [DW-1:0] app_rd_data;
  logic          cmd_err;
  logic          addr_alias;
  logic [31:0]   wr_count;
  logic [31:0]   rd_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  qdr_ui_responder #(
    .DATA_WIDTH(DW), .BW_WIDTH(BWW), .ADDR_WIDTH(AW), .MEM_ADDR_BITS(MAB),
    .CALIB_CYCLES(CAL), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_clk(rst_clk), .init_calib_complete(init_calib_complete),
    .app_wr_cmd(app_wr_cmd), .app_wr_addr(app_wr_addr), .app_wr_data(app_wr_data),
    .app_wr_bw_n(app_wr_bw_n), .app_rd_cmd(app_rd_cmd), .app_rd_addr(app_rd_addr),
    .app_rd_valid(app_rd_valid), .app_rd_data(app_rd_data), .cmd_err(cmd_err),
    .addr_alias(addr_alias), .wr_count(wr_count), .rd_count(rd_count)
  );

  // Reference model: cycles since reset release decide readiness, reads are
  // queued with their due edge, and memory is a plain array of words.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           rq[$];
  logic [DW-1:0] mem_m [1024];
  int            edge_n = 0;
  int            rel_edge = 0;
  bit            rel_seen = 0;
  bit            m_ready;
  logic          m_init, m_valid, m_err, m_alias;
  logic [DW-1:0] m_data;
  logic [31:0]   m_wr, m_rd;
  bit            mon_en = 0;

  always @(posedge clk) begin
    logic [DW-1:0] w;
    edge_n++;
    if (rst_clk) begin
      rel_seen = 0;
      rq.delete();
      m_init = 0; m_valid = 0; m_data = '0; m_err = 0; m_alias = 0;
      m_wr = '0; m_rd = '0;
    end else begin
      if (!rel_seen) begin
        rel_seen = 1;
        rel_edge = edge_n;
      end
      m_ready = (edge_n - rel_edge) >= CAL;
      if ((app_wr_cmd || app_rd_cmd) && !m_ready) m_err = 1;
      if (m_ready && app_rd_cmd) begin
        rq.push_back('{due: edge_n + LAT - 1, data: mem_m[int'(app_rd_addr) % 1024]});
        if (m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 1;
        if (int'(app_rd_addr) >= 1024) m_alias = 1;
      end
      if (m_ready && app_wr_cmd) begin
        w = mem_m[int'(app_wr_addr) % 1024];
        for (int b = 0; b < BWW; b++)
          if (!app_wr_bw_n[b]) w[b*9 +: 9] = app_wr_data[b*9 +: 9];
        mem_m[int'(app_wr_addr) % 1024] = w;
        if (m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
        if (int'(app_wr_addr) >= 1024) m_alias = 1;
      end
      m_init = (edge_n - rel_edge) >= CAL - 1;
      m_valid = 0;
      if (rq.size() > 0 && rq[0].due == edge_n) begin
        m_valid = 1;
        m_data = rq[0].data;
        void'(rq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      vectors += 7;
      if (init_calib_complete !== m_init) begin
        miscompares++; $display("FAIL mon_init edge=%0d got=%b exp=%b", edge_n, init_calib_complete, m_init);
      end
      if (app_rd_valid !== m_valid) begin
        miscompares++; $display("FAIL mon_valid edge=%0d got=%b exp=%b", edge_n, app_rd_valid, m_valid);
      end
      if (app_rd_data !== m_data) begin
        miscompares++; $display("FAIL mon_data edge=%0d got=%h exp=%h", edge_n, app_rd_data, m_data);
      end
      if (cmd_err !== m_err) begin
        miscompares++; $display("FAIL mon_cmd_err edge=%0d got=%b exp=%b", edge_n, cmd_err, m_err);
      end
      if (addr_alias !== m_alias) begin
        miscompares++; $display("FAIL mon_alias edge=%0d got=%b exp=%b", edge_n, addr_alias, m_alias);
      end
      if (wr_count !== m_wr) begin
        miscompares++; $display("FAIL mon_wr_count edge=%0d got=%0d exp=%0d", edge_n, wr_count, m_wr);
      end
      if (rd_count !== m_rd) begin
        miscompares++; $display("FAIL mon_rd_count edge=%0d got=%0d exp=%0d", edge_n, rd_count, m_rd);
      end
    end
  end

  function automatic logic [DW-1:0] rand_data();
    logic [159:0] r;
    for (int i = 0; i < 5; i++) r[i*32 +: 32] = $urandom;
    return r[DW-1:0];
  endfunction

  // One clock cycle of stimulus; strobes drop again after the edge.
  task automatic drive(input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [BWW-1:0] bw, input bit rd, input logic [AW-1:0] ra);
    app_wr_cmd = wr; app_wr_addr = wa; app_wr_data = wd; app_wr_bw_n = bw;
    app_rd_cmd = rd; app_rd_addr = ra;
    @(negedge clk);
    app_wr_cmd = 0; app_rd_cmd = 0;
  endtask

  task automatic idle(input int n);
    app_wr_cmd = 0; app_rd_cmd = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_clk = 1;
    idle(2);
    mon_en = 1;
    idle(1);
    vectors += 4;
    if (init_calib_complete !== 1'b0) begin
      miscompares++; $display("FAIL reset_init got=%b exp=0", init_calib_complete);
    end
    if (app_rd_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid got=%b exp=0", app_rd_valid);
    end
    if (app_rd_data !== '0) begin
      miscompares++; $display("FAIL reset_data got=%h exp=0", app_rd_data);
    end
    if ({cmd_err, addr_alias, wr_count, rd_count} !== '0) begin
      miscompares++; $display("FAIL reset_flags got=%b%b %0d %0d exp=all zero", cmd_err, addr_alias, wr_count, rd_count);
    end
  endtask

  task automatic test_calibration();
    rst_clk = 0;
    for (int k = 0; k < CAL; k++) begin
      if (k == 10) drive(1, 19'h00010, rand_data(), '0, 0, '0);
      else idle(1);
      if (k == 10) begin
        vectors += 2;
        if (cmd_err !== 1'b1) begin
          miscompares++; $display("FAIL calib_cmd_err got=%b exp=1", cmd_err);
        end
        if (wr_count !== 32'd0) begin
          miscompares++; $display("FAIL calib_wr_count got=%0d exp=0", wr_count);
        end
      end
      if (k == CAL - 2) begin
        vectors++;
        if (init_calib_complete !== 1'b0) begin
          miscompares++; $display("FAIL calib_early got=%b exp=0", init_calib_complete);
        end
      end
      if (k == CAL - 1) begin
        vectors++;
        if (init_calib_complete !== 1'b1) begin
          miscompares++; $display("FAIL calib_done got=%b exp=1", init_calib_complete);
        end
      end
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    d = 144'h123456789ABCDEF0_0FEDCBA987654321_ABCD;
    drive(1, 19'h00005, d, 16'h0000, 0, '0);
    drive(0, '0, '0, '1, 1, 19'h00005);
    for (int k = 2; k <= LAT; k++) begin
      vectors++;
      if (app_rd_valid !== 1'b0) begin
        miscompares++; $display("FAIL single_early k=%0d got=%b exp=0", k - 1, app_rd_valid);
      end
      idle(1);
    end
    vectors += 4;
    if (app_rd_valid !== 1'b1) begin
      miscompares++; $display("FAIL single_valid got=%b exp=1", app_rd_valid);
    end
    if (app_rd_data !== d) begin
      miscompares++; $display("FAIL single_data got=%h exp=%h", app_rd_data, d);
    end
    if (wr_count !== 32'd1) begin
      miscompares++; $display("FAIL single_wr_count got=%0d exp=1", wr_count);
    end
    if (rd_count !== 32'd1) begin
      miscompares++; $display("FAIL single_rd_count got=%0d exp=1", rd_count);
    end
    idle(1);
    vectors++;
    if (app_rd_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_pulse_width got=%b exp=0", app_rd_valid);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) drive(1, AW'(i), rand_data(), '0, 0, '0);
  endtask

  task automatic test_byte_mask();
    logic [DW-1:0] exp_d;
    exp_d = '1;
    exp_d[8:0] = '0;
    drive(1, 19'h00014, '1, 16'h0000, 0, '0);
    drive(1, 19'h00014, '0, 16'hFFFE, 0, '0);
    drive(0, '0, '0, '1, 1, 19'h00014);
    idle(LAT - 1);
    vectors += 2;
    if (app_rd_valid !== 1'b1) begin
      miscompares++; $display("FAIL mask_valid got=%b exp=1", app_rd_valid);
    end
    if (app_rd_data !== exp_d) begin
      miscompares++; $display("FAIL mask_data got=%h exp=%h", app_rd_data, exp_d);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [8];
    drive(1, 19'h00007, 144'hA, '0, 0, '0);
    drive(1, 19'h00007, 144'hB, '0, 1, 19'h00007);
    idle(LAT - 1);
    vectors += 2;
    if (app_rd_valid !== 1'b1) begin
      miscompares++; $display("FAIL collide_valid got=%b exp=1", app_rd_valid);
    end
    if (app_rd_data !== 144'hA) begin
      miscompares++; $display("FAIL collide_data got=%h exp=a", app_rd_data);
    end
    for (int i = 0; i < 8; i++) exp_d[i] = mem_m[i];
    for (int j = 0; j < 8 + LAT; j++) begin
      if (j < 8) drive(0, '0, '0, '1, 1, AW'(j));
      else idle(1);
      vectors++;
      if (j >= LAT - 1 && j < LAT + 7) begin
        if (app_rd_valid !== 1'b1 || app_rd_data !== exp_d[j - LAT + 1]) begin
          miscompares++;
          $display("FAIL stream_beat%0d got=%b/%h exp=1/%h", j - LAT + 1, app_rd_valid, app_rd_data, exp_d[j - LAT + 1]);
        end
      end else if (app_rd_valid !== 1'b0) begin
        miscompares++; $display("FAIL stream_gap j=%0d got=%b exp=0", j, app_rd_valid);
      end
    end
  endtask

  task automatic test_alias();
    logic [DW-1:0] d;
    d = rand_data();
    drive(1, 19'h00400, d, '0, 0, '0);
    drive(0, '0, '0, '1, 1, 19'h00000);
    idle(LAT - 1);
    vectors += 2;
    if (app_rd_data !== d) begin
      miscompares++; $display("FAIL alias_data got=%h exp=%h", app_rd_data, d);
    end
    if (addr_alias !== 1'b1) begin
      miscompares++; $display("FAIL alias_flag got=%b exp=1", addr_alias);
    end
  endtask

  task automatic test_random(input int n);
    logic [AW-1:0] wa, ra;
    logic [BWW-1:0] bw;
    for (int k = 0; k < n; k++) begin
      wa = AW'($urandom_range(0, 15));
      ra = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) wa[AW-1:MAB] = (AW-MAB)'($urandom);
      if ($urandom_range(0, 7) == 0) ra[AW-1:MAB] = (AW-MAB)'($urandom);
      case ($urandom_range(0, 3))
        0: bw = '0;
        1: bw = '1;
        default: bw = BWW'($urandom);
      endcase
      drive(bit'($urandom_range(0, 1)), wa, rand_data(), bw, bit'($urandom_range(0, 1)), ra);
    end
    idle(LAT + 2);
  endtask

  task automatic test_reset_midflight();
    int pulses;
    drive(0, '0, '0, '1, 1, 19'h00001);
    drive(0, '0, '0, '1, 1, 19'h00002);
    drive(0, '0, '0, '1, 1, 19'h00003);
    idle(1);
    vectors++;
    if (app_rd_valid !== 1'b1) begin
      miscompares++; $display("FAIL midflight_first got=%b exp=1", app_rd_valid);
    end
    rst_clk = 1;
    idle(1);
    rst_clk = 0;
    vectors += 2;
    if (app_rd_valid !== 1'b0) begin
      miscompares++; $display("FAIL midflight_valid got=%b exp=0", app_rd_valid);
    end
    if (init_calib_complete !== 1'b0) begin
      miscompares++; $display("FAIL midflight_init got=%b exp=0", init_calib_complete);
    end
    pulses = 0;
    for (int k = 0; k < CAL; k++) begin
      idle(1);
      if (app_rd_valid === 1'b1) pulses++;
      if (k == CAL - 2) begin
        vectors++;
        if (init_calib_complete !== 1'b0) begin
          miscompares++; $display("FAIL recal_early got=%b exp=0", init_calib_complete);
        end
      end
    end
    vectors += 2;
    if (pulses != 0) begin
      miscompares++; $display("FAIL midflight_stale got=%0d exp=0", pulses);
    end
    if (init_calib_complete !== 1'b1) begin
      miscompares++; $display("FAIL recal_done got=%b exp=1", init_calib_complete);
    end
  endtask

  initial begin
    test_reset();
    test_calibration();
    test_single();
    preload();
    test_byte_mask();
    test_back_to_back();
    test_alias();
    test_random(400);
    test_reset_midflight();
    test_random(200);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
